// File: rtl/free_list_pkg.sv
// Shared constants and pointer helpers for the physical-register free list.
//   NUM_PREGS / ARCH_REGS : physical and architectural register counts
//   PREG_W                : width of a physical register tag
//   DEPTH                 : circular-buffer slots (every nonzero preg fits)
//   PTR_W / CNT_W         : pointer and occupancy widths
//   ZERO_PREG             : hard-wired zero register, never allocated or freed
// Helpers:
//   ptr_add / ptr_sub     : modulo-DEPTH pointer moves by 0..3, using an
//                           explicit wrap compare (DEPTH is not a power of 2)
//   tag_valid             : an enabled lane that carries a non-zero tag
package free_list_pkg;

    localparam int NUM_PREGS  = 64;
    localparam int ARCH_REGS  = 32;
    localparam int PREG_W     = $clog2(NUM_PREGS);
    localparam int DEPTH      = NUM_PREGS - 1;
    localparam int PTR_W      = $clog2(DEPTH);
    localparam int CNT_W      = $clog2(NUM_PREGS) + 1;
    localparam int RESET_FREE = NUM_PREGS - ARCH_REGS;

    localparam logic [PREG_W-1:0] ZERO_PREG = '0;

    // DEPTH at pointer-plus-carry width, so wrap compares stay width-matched.
    localparam logic [PTR_W:0] DEPTH_X = (PTR_W + 1)'(DEPTH);

    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] ptr,
                                                 input logic [1:0]       n);
        logic [PTR_W:0] sum;
        sum = {1'b0, ptr} + {{(PTR_W - 1){1'b0}}, n};
        return (sum >= DEPTH_X) ? PTR_W'(sum - DEPTH_X) : PTR_W'(sum);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_sub(input logic [PTR_W-1:0] ptr,
                                                 input logic [1:0]       n);
        logic [PTR_W:0] wide;
        logic [PTR_W:0] n_ext;
        wide  = {1'b0, ptr};
        n_ext = {{(PTR_W - 1){1'b0}}, n};
        return (wide >= n_ext) ? PTR_W'(wide - n_ext)
                               : PTR_W'(wide + DEPTH_X - n_ext);
    endfunction

    function automatic logic tag_valid(input logic              en,
                                       input logic [PREG_W-1:0] tag);
        return en && (tag != ZERO_PREG);
    endfunction

endpackage

// File: rtl/free_list.sv
// Physical-register free list for the 2-wide out-of-order core.
// A circular buffer of free preg tags: dispatch takes tags from the head,
// ROB retire returns t_old tags at the tail, and a branch rewind gives the
// squashed tags back by rolling the head backwards.
//
// Ports:
//   clock          system clock
//   reset          synchronous, active-high; restores the reset image
//   num_to_alloc   tags dispatch takes this cycle (0..2)
//   alloc_tags     [PREG_W-1:0] = slot head, [2*PREG_W-1:PREG_W] = slot head+1
//   num_can_alloc  min(count, 2)
//   free_en        per-lane retire enable
//   free_tags      per-lane t_old tag (lane i at [i*PREG_W +: PREG_W])
//   rewind_en      per-entry squash enable, entry 0 youngest
//   rewind_tags    per-entry squashed tag (entry i at [i*PREG_W +: PREG_W])
//   free_count     current occupancy
//
// Allocation handshake: num_can_alloc is the offer and num_to_alloc the
// take; dispatch may only take tags that are offered in the same cycle
// (num_to_alloc <= num_can_alloc), and the taken tags are those shown on
// alloc_tags[0..num_to_alloc-1]. Freed or rewound tags are offered from the
// following cycle on. Allocating in a rewind cycle is illegal.
module free_list
    import free_list_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            num_to_alloc,
    output logic [2*PREG_W-1:0]   alloc_tags,
    output logic [1:0]            num_can_alloc,
    input  logic [1:0]            free_en,
    input  logic [2*PREG_W-1:0]   free_tags,
    input  logic [2:0]            rewind_en,
    input  logic [3*PREG_W-1:0]   rewind_tags,
    output logic [CNT_W-1:0]      free_count
);

    logic [PREG_W-1:0] slots_q [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              free_v0, free_v1;
    logic [1:0]        n_free;
    logic [1:0]        n_rew;
    logic              wr0_en, wr1_en;
    logic [PTR_W-1:0]  wr0_idx, wr1_idx;
    logic [PREG_W-1:0] wr0_tag, wr1_tag;
    logic [PTR_W-1:0]  head_p1;

    always_comb begin
        free_v0 = tag_valid(free_en[0], free_tags[0 +: PREG_W]);
        free_v1 = tag_valid(free_en[1], free_tags[PREG_W +: PREG_W]);
        n_free  = {1'b0, free_v0} + {1'b0, free_v1};

        n_rew = {1'b0, tag_valid(rewind_en[0], rewind_tags[0 +: PREG_W])}
              + {1'b0, tag_valid(rewind_en[1], rewind_tags[PREG_W +: PREG_W])}
              + {1'b0, tag_valid(rewind_en[2], rewind_tags[2*PREG_W +: PREG_W])};

        // Valid free tags are compacted: the first valid one always lands at
        // tail, so a lone lane-1 tag does not leave a hole.
        wr0_en  = free_v0 | free_v1;
        wr0_idx = tail_q;
        wr0_tag = free_v0 ? free_tags[0 +: PREG_W] : free_tags[PREG_W +: PREG_W];
        wr1_en  = free_v0 & free_v1;
        wr1_idx = ptr_add(tail_q, 2'd1);
        wr1_tag = free_tags[PREG_W +: PREG_W];

        // Alloc and rewind never coincide, so applying both moves in sequence
        // is just whichever one is active. Rewound tags are still in the slots
        // behind head, so only the pointer moves.
        head_d  = ptr_sub(ptr_add(head_q, num_to_alloc), n_rew);
        tail_d  = ptr_add(tail_q, n_free);
        count_d = count_q - CNT_W'(num_to_alloc) + CNT_W'(n_free) + CNT_W'(n_rew);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= PTR_W'(RESET_FREE);
            count_q <= CNT_W'(RESET_FREE);
            for (int k = 0; k < DEPTH; k++) begin
                slots_q[k] <= (k < RESET_FREE) ? PREG_W'(ARCH_REGS + k) : ZERO_PREG;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (wr0_en) begin
                slots_q[wr0_idx] <= wr0_tag;
            end
            if (wr1_en) begin
                slots_q[wr1_idx] <= wr1_tag;
            end
        end
    end

    assign head_p1       = ptr_add(head_q, 2'd1);
    assign alloc_tags    = {slots_q[head_p1], slots_q[head_q]};
    assign num_can_alloc = (count_q >= CNT_W'(2)) ? 2'd2 : count_q[1:0];
    assign free_count    = count_q;

    // Protocol misuse is flagged, never clamped.
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (!((num_to_alloc != 2'd0) && (|rewind_en)));
            assert (num_to_alloc <= num_can_alloc);
            assert (count_d <= CNT_W'(DEPTH));
        end
    end

endmodule

// File: tb/tb_free_list.sv
module tb_free_list;
    import free_list_pkg::*;

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic [1:0]            num_to_alloc;
    logic [2*PREG_W-1:0]   alloc_tags;
    logic [1:0]            num_can_alloc;
    logic [1:0]            free_en;
    logic [2*PREG_W-1:0]   free_tags;
    logic [2:0]            rewind_en;
    logic [3*PREG_W-1:0]   rewind_tags;
    logic [CNT_W-1:0]      free_count;

    free_list dut (
        .clock         (clock),
        .reset         (reset),
        .num_to_alloc  (num_to_alloc),
        .alloc_tags    (alloc_tags),
        .num_can_alloc (num_can_alloc),
        .free_en       (free_en),
        .free_tags     (free_tags),
        .rewind_en     (rewind_en),
        .rewind_tags   (rewind_tags),
        .free_count    (free_count)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_pass   = 0;

    // Free tags in allocation order: alloc pops the front, free pushes the
    // back, rewind pushes the front.
    logic [PREG_W-1:0] exp_q[$];

    typedef struct {
        logic [PREG_W-1:0] arch;
        logic [PREG_W-1:0] new_p;
        logic [PREG_W-1:0] old_p;
    } rob_t;
    rob_t              rob_q[$];
    logic [PREG_W-1:0] rat[ARCH_REGS];

    typedef struct {
        logic [1:0]        na;
        logic [1:0]        fen;
        logic [PREG_W-1:0] ft0, ft1;
        logic [2:0]        ren;
        logic [PREG_W-1:0] rt0, rt1, rt2;
        int                exp_cnt;
        int                exp_can;
        int                exp_t0;
        int                exp_t1;
    } vec_t;
    vec_t vecs[9];

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic set_inputs(input logic [1:0] na, input logic [1:0] fen,
                              input logic [PREG_W-1:0] ft0, input logic [PREG_W-1:0] ft1,
                              input logic [2:0] ren, input logic [PREG_W-1:0] rt0,
                              input logic [PREG_W-1:0] rt1, input logic [PREG_W-1:0] rt2);
        num_to_alloc = na;
        free_en      = fen;
        free_tags    = {ft1, ft0};
        rewind_en    = ren;
        rewind_tags  = {rt2, rt1, rt0};
    endtask

    task automatic idle_inputs();
        set_inputs(2'd0, 2'b00, '0, '0, 3'b000, '0, '0, '0);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset();
        exp_q.delete();
        rob_q.delete();
        for (int p = ARCH_REGS; p < NUM_PREGS; p++) exp_q.push_back(PREG_W'(p));
        for (int a = 0; a < ARCH_REGS; a++) rat[a] = PREG_W'(a);
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
    endtask

    task automatic check_model(input string tag);
        int sz;
        sz = exp_q.size();
        check({tag, ".count"}, int'(free_count), sz);
        check({tag, ".can"}, int'(num_can_alloc), (sz >= 2) ? 2 : sz);
        if (sz >= 1) check({tag, ".t0"}, int'(alloc_tags[PREG_W-1:0]), int'(exp_q[0]));
        if (sz >= 2) check({tag, ".t1"}, int'(alloc_tags[2*PREG_W-1:PREG_W]), int'(exp_q[1]));
    endtask

    task automatic check_image(input string tag, input int cnt, input int can,
                               input int t0, input int t1);
        check({tag, ".count"}, int'(free_count), cnt);
        check({tag, ".can"}, int'(num_can_alloc), can);
        if (can >= 1) check({tag, ".t0"}, int'(alloc_tags[PREG_W-1:0]), t0);
        if (can >= 2) check({tag, ".t1"}, int'(alloc_tags[2*PREG_W-1:PREG_W]), t1);
    endtask

    // One random cycle of legal traffic plus the matching model update.
    task automatic random_cycle();
        int rsz, k, na, nret, lane;
        logic [PREG_W-1:0] ft0, ft1;
        logic [PREG_W-1:0] rt[3];
        logic [1:0] fen;
        logic [2:0] ren;
        rob_t e;

        rsz = rob_q.size();
        k   = 0;
        na  = 0;
        if (rsz > 0 && $urandom_range(0, 7) == 0) begin
            k = $urandom_range(1, (rsz < 3) ? rsz : 3);
        end else begin
            na = $urandom_range(0, (exp_q.size() < 2) ? exp_q.size() : 2);
        end
        nret = $urandom_range(0, ((rsz - k) < 2) ? (rsz - k) : 2);

        ft0 = PREG_W'($urandom_range(0, NUM_PREGS - 1));
        ft1 = PREG_W'($urandom_range(0, NUM_PREGS - 1));
        fen = 2'b00;
        lane = 0;
        if (nret == 2) begin
            fen = 2'b11;
            ft0 = rob_q[0].old_p;
            ft1 = rob_q[1].old_p;
        end else if (nret == 1) begin
            lane = $urandom_range(0, 1);
            if (lane == 0) begin fen = 2'b01; ft0 = rob_q[0].old_p; end
            else           begin fen = 2'b10; ft1 = rob_q[0].old_p; end
        end

        ren = 3'b000;
        for (int i = 0; i < 3; i++) begin
            if (i < k) begin
                rt[i] = rob_q[rsz - 1 - i].new_p;
                ren[i] = 1'b1;
            end else begin
                rt[i] = PREG_W'($urandom_range(0, NUM_PREGS - 1));
            end
        end

        set_inputs(2'(na), fen, ft0, ft1, ren, rt[0], rt[1], rt[2]);
        tick();

        // Reference: take from the front, retire oldest, squash youngest.
        for (int j = 0; j < nret; j++) begin
            e = rob_q.pop_front();
            exp_q.push_back(e.old_p);
        end
        for (int i = 0; i < k; i++) begin
            e = rob_q.pop_back();
            rat[e.arch] = e.old_p;
            exp_q.push_front(e.new_p);
        end
        for (int j = 0; j < na; j++) begin
            e.new_p = exp_q.pop_front();
            e.arch  = PREG_W'($urandom_range(1, ARCH_REGS - 1));
            e.old_p = rat[e.arch];
            rat[e.arch] = e.new_p;
            rob_q.push_back(e);
        end
        check_model("rand");
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int seen[NUM_PREGS];
        int bad;
        int n;
        int guard;

        vecs[0] = '{2'd2, 2'b00, 6'd0,  6'd0,  3'b000, 6'd0,  6'd0,  6'd0, 30, 2, 34, 35};
        vecs[1] = '{2'd0, 2'b00, 6'd0,  6'd0,  3'b011, 6'd32, 6'd33, 6'd0, 32, 2, 32, 33};
        vecs[2] = '{2'd0, 2'b11, 6'd45, 6'd0,  3'b000, 6'd0,  6'd0,  6'd0, 33, 2, 32, 33};
        vecs[3] = '{2'd1, 2'b00, 6'd0,  6'd0,  3'b000, 6'd0,  6'd0,  6'd0, 32, 2, 33, 34};
        vecs[4] = '{2'd0, 2'b11, 6'd5,  6'd7,  3'b000, 6'd0,  6'd0,  6'd0, 34, 2, 33, 34};
        vecs[5] = '{2'd0, 2'b10, 6'd3,  6'd9,  3'b000, 6'd0,  6'd0,  6'd0, 35, 2, 33, 34};
        vecs[6] = '{2'd0, 2'b00, 6'd0,  6'd0,  3'b000, 6'd0,  6'd0,  6'd0, 35, 2, 33, 34};
        vecs[7] = '{2'd0, 2'b00, 6'd0,  6'd0,  3'b001, 6'd32, 6'd0,  6'd0, 36, 2, 32, 33};
        vecs[8] = '{2'd0, 2'b01, 6'd0,  6'd22, 3'b010, 6'd20, 6'd0,  6'd0, 36, 2, 32, 33};

        idle_inputs();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        model_reset();

        // Reset image
        check_image("reset", 32, 2, 32, 33);

        // Directed vectors from the reset image
        for (int i = 0; i < 9; i++) begin
            set_inputs(vecs[i].na, vecs[i].fen, vecs[i].ft0, vecs[i].ft1,
                       vecs[i].ren, vecs[i].rt0, vecs[i].rt1, vecs[i].rt2);
            tick();
            check_image($sformatf("vec%0d", i), vecs[i].exp_cnt, vecs[i].exp_can,
                        vecs[i].exp_t0, vecs[i].exp_t1);
        end

        // Empty boundary, then refill one tag at a time
        do_reset();
        for (int i = 0; i < 16; i++) begin
            set_inputs(2'd2, 2'b00, '0, '0, 3'b000, '0, '0, '0);
            tick();
        end
        idle_inputs();
        check_image("empty", 0, 0, 0, 0);
        set_inputs(2'd0, 2'b01, 6'd40, 6'd0, 3'b000, '0, '0, '0);
        #1;
        check("no_bypass.can", int'(num_can_alloc), 0);
        tick();
        idle_inputs();
        check_image("one_free", 1, 1, 40, 0);
        // Lane 0 carries ZERO_PREG; lane-1 tag must still land at tail.
        set_inputs(2'd1, 2'b11, 6'd0, 6'd41, 3'b000, '0, '0, '0);
        tick();
        check_image("compact", 1, 1, 41, 0);
        set_inputs(2'd0, 2'b10, 6'd43, 6'd42, 3'b000, '0, '0, '0);
        tick();
        idle_inputs();
        check_image("lane1_only", 2, 2, 41, 42);

        // Rewind with a ZERO_PREG entry, together with two frees, then reset
        do_reset();
        set_inputs(2'd2, 2'b00, '0, '0, 3'b000, '0, '0, '0);
        tick();
        set_inputs(2'd0, 2'b11, 6'd3, 6'd4, 3'b111, 6'd33, 6'd0, 6'd32);
        tick();
        idle_inputs();
        check_image("rewind_free", 34, 2, 32, 33);
        reset = 1'b1;
        set_inputs(2'd2, 2'b11, 6'd5, 6'd6, 3'b000, '0, '0, '0);
        tick();
        reset = 1'b0;
        idle_inputs();
        check_image("mid_reset", 32, 2, 32, 33);
        tick();
        check_image("post_reset", 32, 2, 32, 33);

        // Random legal traffic against the queue model
        do_reset();
        for (int c = 0; c < 200; c++) random_cycle();
        idle_inputs();

        // Drain every free tag out of the DUT and account for all pregs
        for (int p = 0; p < NUM_PREGS; p++) seen[p] = 0;
        guard = 0;
        while (exp_q.size() > 0 && guard < 80) begin
            n = (exp_q.size() < 2) ? exp_q.size() : 2;
            seen[alloc_tags[PREG_W-1:0]]++;
            if (n == 2) seen[alloc_tags[2*PREG_W-1:PREG_W]]++;
            set_inputs(2'(n), 2'b00, '0, '0, 3'b000, '0, '0, '0);
            tick();
            for (int j = 0; j < n; j++) void'(exp_q.pop_front());
            guard++;
        end
        idle_inputs();
        check("drain.count", int'(free_count), 0);
        for (int a = 1; a < ARCH_REGS; a++) seen[rat[a]]++;
        foreach (rob_q[i]) seen[rob_q[i].old_p]++;
        bad = (seen[0] != 0) ? 1 : 0;
        for (int p = 1; p < NUM_PREGS; p++) if (seen[p] != 1) bad++;
        check("multiset.bad_pregs", bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
